// File: rtl/reg32_pkg.sv
// rtl/reg32_pkg.sv - shared defaults for the reg32 storage register
package reg32_pkg;

    localparam int unsigned REG32_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/reg32.sv
// rtl/reg32.sv - single-word register with write enable and synchronous clear
module reg32
    import reg32_pkg::*;
#(
    parameter int unsigned             WIDTH       = REG32_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]        RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wen,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (wen) begin
            data_d = writedata;
        end
    end

    // Reset wins over a concurrent write; the write is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign readdata = data_q;

endmodule

// File: tb/tb_reg32.sv
// tb/tb_reg32.sv - directed self-checking bench for reg32
module tb_reg32;

    logic        clk;
    logic        reset;
    logic        wen;
    logic [31:0] writedata;
    logic [31:0] readdata;

    int checks;
    int errors;

    reg32 dut (
        .clk       (clk),
        .reset     (reset),
        .wen       (wen),
        .writedata (writedata),
        .readdata  (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        wen       = 1'b0;
        writedata = 32'h0;
        step();
        checks++;
        if (readdata !== 32'h00000000) begin
            errors++;
            $display("FAIL reset: readdata=%h expected=%h", readdata, 32'h00000000);
        end
    endtask

    task automatic test_reset_hold();
        reset     = 1'b1;
        wen       = 1'b0;
        writedata = 32'h13579BDF;
        step();
        step();
        checks++;
        if (readdata !== 32'h00000000) begin
            errors++;
            $display("FAIL reset_hold: readdata=%h expected=%h", readdata, 32'h00000000);
        end
        reset = 1'b0;
    endtask

    task automatic test_write();
        reset     = 1'b0;
        wen       = 1'b1;
        writedata = 32'h12345678;
        #2;
        checks++;
        if (readdata !== 32'h00000000) begin
            errors++;
            $display("FAIL write_pre_edge: readdata=%h expected=%h", readdata, 32'h00000000);
        end
        step();
        checks++;
        if (readdata !== 32'h12345678) begin
            errors++;
            $display("FAIL write: readdata=%h expected=%h", readdata, 32'h12345678);
        end
        wen = 1'b0;
    endtask

    task automatic test_hold();
        reset     = 1'b0;
        wen       = 1'b1;
        writedata = 32'hDEADBEEF;
        step();
        checks++;
        if (readdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hold_store: readdata=%h expected=%h", readdata, 32'hDEADBEEF);
        end
        wen       = 1'b0;
        writedata = 32'hFEEDFACE;
        #2;
        writedata = 32'h0BADF00D;
        step();
        checks++;
        if (readdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hold: readdata=%h expected=%h", readdata, 32'hDEADBEEF);
        end
    endtask

    task automatic test_no_comb_path();
        reset     = 1'b0;
        wen       = 1'b1;
        writedata = 32'hCAFEBABE;
        #2;
        checks++;
        if (readdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL no_comb_path: readdata=%h expected=%h", readdata, 32'hDEADBEEF);
        end
        wen = 1'b0;
        step();
        checks++;
        if (readdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wen_dropped: readdata=%h expected=%h", readdata, 32'hDEADBEEF);
        end
    endtask

    task automatic test_reset_priority();
        reset     = 1'b1;
        wen       = 1'b1;
        writedata = 32'hFFFFFFFF;
        step();
        checks++;
        if (readdata !== 32'h00000000) begin
            errors++;
            $display("FAIL reset_priority: readdata=%h expected=%h", readdata, 32'h00000000);
        end
        reset = 1'b0;
        wen   = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vec [3];
        vec[0] = 32'h00000001;
        vec[1] = 32'hAAAAAAAA;
        vec[2] = 32'hFFFFFFFF;
        reset  = 1'b0;
        wen    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            writedata = vec[i];
            step();
            checks++;
            if (readdata !== vec[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: readdata=%h expected=%h", i, readdata, vec[i]);
            end
        end
        wen = 1'b0;
    endtask

    task automatic test_reset_resume();
        reset     = 1'b0;
        wen       = 1'b1;
        writedata = 32'h0000000A;
        step();
        checks++;
        if (readdata !== 32'h0000000A) begin
            errors++;
            $display("FAIL resume_store: readdata=%h expected=%h", readdata, 32'h0000000A);
        end
        reset = 1'b1;
        wen   = 1'b0;
        step();
        checks++;
        if (readdata !== 32'h00000000) begin
            errors++;
            $display("FAIL resume_reset: readdata=%h expected=%h", readdata, 32'h00000000);
        end
        reset     = 1'b0;
        wen       = 1'b1;
        writedata = 32'h55555555;
        step();
        checks++;
        if (readdata !== 32'h55555555) begin
            errors++;
            $display("FAIL resume_write: readdata=%h expected=%h", readdata, 32'h55555555);
        end
        wen = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        wen       = 1'b0;
        writedata = 32'h0;
        test_reset();
        test_reset_hold();
        test_write();
        test_hold();
        test_no_comb_path();
        test_reset_priority();
        test_back_to_back();
        test_reset_resume();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
